// File: rtl/mmio_uart_tx_if.sv
// Core data-bus view of the UART transmitter's register window.
// The core side (master) drives address, store data and the write strobe;
// the UART side (slave) returns combinational read data and its select flag.
interface mmio_uart_tx_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic [31:0] rdata;
  logic        sel;

  modport master (output addr, wdata, mem_write, input rdata, sel);
  modport slave  (input addr, wdata, mem_write, output rdata, sel);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: a 16-byte register window on the core data
// bus feeding a small byte FIFO, drained by an 8N1 serialiser on tx.
// Optional build macro UART_TX_PARITY_EN adds a parity bit (even by default,
// odd when CTRL bit1 is set), making the frame 11 bits.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  mmio_uart_tx_if.slave     bus,
  output logic              tx
);
  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam int              NW         = AW + 1;
  localparam int              CW         = $clog2(CLKS_PER_BIT);
  localparam logic [NW-1:0]   FULL_COUNT = NW'(FIFO_DEPTH);
  localparam logic [CW-1:0]   BAUD_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Bus decode; addr[1:0] and the upper store-data byte lanes are don't-care.
  logic       sel_w, wr_en, push, clr_ovf, ctrl_wr;
  logic [1:0] offset;
  logic       unused_bits;
  assign sel_w       = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign offset      = bus.addr[3:2];
  assign wr_en       = sel_w & bus.mem_write;
  assign push        = wr_en & (offset == 2'd0);
  assign clr_ovf     = wr_en & (offset == 2'd1) & bus.wdata[3];
  assign ctrl_wr     = wr_en & (offset == 2'd2);
  assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:8]};

  // State
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, en_q;
`ifdef UART_TX_PARITY_EN
  logic          odd_q;
`endif
  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          full, empty, pop, push_ok, baud_done;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

  // FIFO bookkeeping: a push into a full FIFO only lands if a pop frees a slot.
  always_comb begin
    push_ok  = push && (!full || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + NW'(push_ok) - NW'(pop);
    ovf_d    = ovf_q;
    if (push && full && !pop) ovf_d = 1'b1;
    if (clr_ovf)              ovf_d = 1'b0;
  end

  // FIFO storage write port.
  // NOTE: the byte array has no reset; count and pointers alone define which
  // entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.wdata[7:0];
  end

  // Serialiser next state, FIFO pop and registered tx level.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d   = state_q;
    bit_d     = bit_q;
    data_d    = data_q;
    pop       = 1'b0;
    baud_done = (baud_q == BAUD_LAST);
    case (state_q)
      S_IDLE: begin
        if (en_q && !empty) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_done) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (baud_done) begin
          if (en_q && !empty) begin
            pop     = 1'b1;
            data_d  = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bit timer restarts on every state change and after each full bit.
    if (state_d != state_q || state_d == S_IDLE || baud_done) baud_d = '0;
    else                                                      baud_d = baud_q + 1'b1;

    // tx is registered from the next state so the pin never glitches.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_d[bit_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = (^data_d) ^ odd_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // State registers with synchronous reset; FIFO contents are dropped by
  // zeroing the count.
  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      en_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      odd_q    <= 1'b0;
`endif
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (ctrl_wr) begin
        en_q  <= bus.wdata[0];
`ifdef UART_TX_PARITY_EN
        odd_q <= bus.wdata[1];
`endif
      end
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
    end
  end

  // Zero-latency register read; outside the window rdata is 0 so the top
  // level can OR it with the data RAM read path.
  logic [31:0] status, ctrl_rd, rdata_w;
  always_comb begin
    status        = '0;
    status[0]     = full;
    status[1]     = empty;
    status[2]     = (state_q != S_IDLE);
    status[3]     = ovf_q;
    status[14:8]  = 7'(count_q);
    ctrl_rd       = '0;
    ctrl_rd[0]    = en_q;
`ifdef UART_TX_PARITY_EN
    ctrl_rd[1]    = odd_q;
`endif
    rdata_w       = '0;
    if (sel_w) begin
      case (offset)
        2'd1:    rdata_w = status;
        2'd2:    rdata_w = ctrl_rd;
        default: rdata_w = '0;
      endcase
    end
  end

  assign bus.rdata = rdata_w;
  assign bus.sel   = sel_w;
  assign tx        = tx_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4:
// a register-access vector table, then hand-written serial-frame sequences.
module tb_mmio_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
  logic par_odd = 1'b0;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR   (32'h0000_1000),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .tx (tx)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [7:0] tx_bytes [8];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] exp_rdata;
    logic        exp_sel;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] a, input logic [31:0] d, input logic we,
                         input logic [31:0] er, input logic es);
    vec_t v;
    v.addr = a; v.wdata = d; v.we = we; v.exp_rdata = er; v.exp_sel = es;
    vecs.push_back(v);
  endtask

  // Expected tx level at position idx of a frame carrying byte b.
  function automatic logic exp_tx(input logic [7:0] b, input int idx);
    if (idx < CPB) return 1'b0;
    if (idx < 9 * CPB) return b[(idx - CPB) / CPB];
`ifdef UART_TX_PARITY_EN
    if (idx < 10 * CPB) return (^b) ^ par_odd;
`endif
    return 1'b1;
  endfunction

  // Called on a negedge; the write lands on the following rising edge and
  // the task returns on the negedge after it.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.addr      = a;
    bus.wdata     = d;
    bus.mem_write = 1'b1;
    @(negedge clk);
    bus.mem_write = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.addr      = a;
    bus.mem_write = 1'b0;
    #1;
    check(name, bus.rdata, exp);
  endtask

  // Checks n back-to-back frames from tx_bytes, starting with the current
  // cycle as the first start-bit cycle; busy must hold throughout.
  task automatic check_stream(input int n);
    bus.addr = 32'h0000_1004;
    for (int i = 0; i < n * FRAME; i++) begin
      #1;
      check($sformatf("tx f%0d i%0d", i / FRAME, i % FRAME), 32'(tx),
            32'(exp_tx(tx_bytes[i / FRAME], i % FRAME)));
      check($sformatf("busy f%0d i%0d", i / FRAME, i % FRAME), 32'(bus.rdata[2]), 32'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.mem_write = 1'b0;

    // Register vectors, applied in order; rdata/sel are sampled before the edge.
    add_vec(32'h0000_1004, 32'h0,         1'b0, 32'h0000_0002, 1'b1); // empty after reset
    add_vec(32'h0000_2000, 32'h0,         1'b0, 32'h0,         1'b0); // outside window
    add_vec(32'h0000_2000, 32'hAB,        1'b1, 32'h0,         1'b0); // store outside window
    add_vec(32'h0000_1004, 32'h0,         1'b0, 32'h0000_0002, 1'b1); // still empty and idle
    add_vec(32'h0000_1008, 32'h0,         1'b0, 32'h0000_0001, 1'b1); // enable resets to 1
    add_vec(32'h0000_1008, 32'h2,         1'b1, 32'h0000_0001, 1'b1); // disable, odd select
`ifdef UART_TX_PARITY_EN
    add_vec(32'h0000_1008, 32'h0,         1'b0, 32'h0000_0002, 1'b1);
    add_vec(32'h0000_1008, 32'h0,         1'b1, 32'h0000_0002, 1'b1);
`else
    add_vec(32'h0000_1008, 32'h0,         1'b0, 32'h0000_0000, 1'b1);
    add_vec(32'h0000_1008, 32'h0,         1'b1, 32'h0000_0000, 1'b1);
`endif
    add_vec(32'h0000_1008, 32'h0,         1'b0, 32'h0000_0000, 1'b1);
    add_vec(32'h0000_100C, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1); // reserved write
    add_vec(32'h0000_100C, 32'h0,         1'b0, 32'h0,         1'b1);
    add_vec(32'h0000_1008, 32'h0,         1'b0, 32'h0000_0000, 1'b1);
    add_vec(32'h0000_1007, 32'h0,         1'b0, 32'h0000_0002, 1'b1); // addr[1:0] ignored
    add_vec(32'h0000_0FFC, 32'h0,         1'b0, 32'h0,         1'b0); // just below window
    add_vec(32'h0000_1010, 32'h0,         1'b0, 32'h0,         1'b0); // just above window
    add_vec(32'h0000_1000, 32'h01,        1'b1, 32'h0,         1'b1); // TXDATA reads 0
    add_vec(32'h0000_1004, 32'h0,         1'b0, 32'h0000_0100, 1'b1); // count 1
    add_vec(32'h0000_1003, 32'h02,        1'b1, 32'h0,         1'b1);
    add_vec(32'h0000_1000, 32'h03,        1'b1, 32'h0,         1'b1);
    add_vec(32'h0000_1004, 32'h0,         1'b0, 32'h0000_0300, 1'b1); // count 3
    add_vec(32'h0000_1000, 32'h04,        1'b1, 32'h0,         1'b1);
    add_vec(32'h0000_1004, 32'h0,         1'b0, 32'h0000_0401, 1'b1); // count 4, full
    add_vec(32'h0000_1000, 32'h05,        1'b1, 32'h0,         1'b1); // dropped
    add_vec(32'h0000_1004, 32'h0,         1'b0, 32'h0000_0409, 1'b1); // full + overflow
    add_vec(32'h0000_1004, 32'hF7,        1'b1, 32'h0000_0409, 1'b1); // bit3 clear: no effect
    add_vec(32'h0000_1004, 32'h0,         1'b0, 32'h0000_0409, 1'b1);
    add_vec(32'h0000_1004, 32'h08,        1'b1, 32'h0000_0409, 1'b1); // clear overflow
    add_vec(32'h0000_1004, 32'h0,         1'b0, 32'h0000_0401, 1'b1);
    add_vec(32'h0000_1000, 32'h0,         1'b0, 32'h0,         1'b1);

    // Reset
    repeat (3) @(negedge clk);
    check("tx in reset", 32'(tx), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("tx after reset", 32'(tx), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.addr      = vecs[i].addr;
      bus.wdata     = vecs[i].wdata;
      bus.mem_write = vecs[i].we;
      #1;
      check($sformatf("vec%0d rdata", i), bus.rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d sel", i), 32'(bus.sel), 32'(vecs[i].exp_sel));
      @(negedge clk);
    end
    bus.mem_write = 1'b0;

    // Enable with a full FIFO, pushing on the same edge as the first pop:
    // the push must be accepted and five frames follow with no gaps.
    bus_write(32'h0000_1008, 32'h1);
    bus_write(32'h0000_1000, 32'h55);
    read_check("full push+pop status", 32'h0000_1004, 32'h0000_0405);
    tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h02; tx_bytes[2] = 8'h03;
    tx_bytes[3] = 8'h04; tx_bytes[4] = 8'h55;
    check_stream(5);
    read_check("drained status", 32'h0000_1004, 32'h0000_0002);
    check("tx idle after burst", 32'(tx), 32'd1);

    // Single byte into an idle transmitter: tx stays high on the cycle after
    // the write edge, drops on the next.
    @(negedge clk);
    bus_write(32'h0000_1000, 32'hA5);
    read_check("queued status", 32'h0000_1004, 32'h0000_0100);
    check("tx before start", 32'(tx), 32'd1);
    @(negedge clk);
    tx_bytes[0] = 8'hA5;
    check_stream(1);
    read_check("A5 done status", 32'h0000_1004, 32'h0000_0002);

    // Reset during data bit 3 (a 0 bit of 0xA5) with a second byte queued.
    bus_write(32'h0000_1000, 32'hA5);
    bus_write(32'h0000_1000, 32'h33);
    bus.addr = 32'h0000_1004;
    for (int i = 0; i < 17; i++) begin
      #1;
      check($sformatf("pre-reset tx i%0d", i), 32'(tx), 32'(exp_tx(8'hA5, i)));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("tx forced high by reset", 32'(tx), 32'd1);
    read_check("status in reset", 32'h0000_1004, 32'h0000_0002);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("no residual tx c%0d", i), 32'(tx), 32'd1);
    end
    read_check("status after reset", 32'h0000_1004, 32'h0000_0002);
    read_check("ctrl after reset", 32'h0000_1008, 32'h0000_0001);

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones: even parity bit 1, odd parity bit 0.
    @(negedge clk);
    par_odd = 1'b0;
    bus_write(32'h0000_1000, 32'h07);
    @(negedge clk);
    tx_bytes[0] = 8'h07;
    check_stream(1);
    read_check("even frame done", 32'h0000_1004, 32'h0000_0002);
    bus_write(32'h0000_1008, 32'h3);
    read_check("ctrl odd", 32'h0000_1008, 32'h0000_0003);
    par_odd = 1'b1;
    bus_write(32'h0000_1000, 32'h07);
    @(negedge clk);
    check_stream(1);
    read_check("odd frame done", 32'h0000_1004, 32'h0000_0002);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
